// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan path: glyph table, segment
// bit positions and the scan FSM state encoding.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bit positions inside the 8-bit active-low segment bus {a,b,c,d,e,f,g,dp}.
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Active-low {a..g} glyphs for hex digits 0-F.
  localparam logic [6:0] SEG7_HEX [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_display_if.sv
// Host-side bundle for the multiplexed display: frame data in, pin drives
// out, plus the scan FSM state for observation.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // load is a one-cycle fire-and-forget strobe with no ready: the display
  // accepts it on every cycle it is high, and a newer load overwrites an
  // uncommitted older one.
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_level;
  logic                    lz_blank;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;
  scan_state_e             dbg_state;
  logic [IDX_W-1:0]        dbg_idx;

  modport master (
    output digits_in, dp_in, load, blink_mask, blink_level, lz_blank,
    input  seg, an, frame_start, dbg_state, dbg_idx
  );

  modport slave (
    input  digits_in, dp_in, load, blink_mask, blink_level, lz_blank,
    output seg, an, frame_start, dbg_state, dbg_idx
  );

endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low a-g segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb seg_n = SEG7_HEX[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with dead-time, double
// buffered frame data, decimal points, blink mask and leading-zero blanking.
module seg_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic              clk_fast,
  input  logic              rst_n,
  seg_scan_display_if.slave bus
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_LEN = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int TW      = $clog2(MAX_LEN + 1);
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TW-1:0]    DRIVE_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0]    DEAD_LAST  = TW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  scan_state_e           state_q, state_nx;
  logic [IDX_W-1:0]      idx_q, idx_nx;
  logic [TW-1:0]         timer_q, timer_nx;
  logic                  enter_drive;

  logic [DW-1:0]         stage_d_q, shadow_d_q, shadow_d_nx;
  logic [NUM_DIGITS-1:0] stage_dp_q, shadow_dp_q, shadow_dp_nx;
  logic                  pending_q, commit;

  logic [7:0]            seg_q, seg_nx;
  logic [NUM_DIGITS-1:0] an_q, an_nx;
  logic                  frame_start_q, frame_start_nx;

  logic [3:0]            nib_sel;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  all_zero;

  // Scan sequencing: BLANK for DEAD_CYCLES, DRIVE for REFRESH_DIV, idx
  // advancing as each DRIVE ends.
  always_comb begin
    state_nx    = state_q;
    idx_nx      = idx_q;
    timer_nx    = timer_q + 1'b1;
    enter_drive = 1'b0;
    case (state_q)
      BLANK: begin
        if (DEAD_CYCLES == 0 || timer_q == DEAD_LAST) begin
          state_nx    = DRIVE;
          timer_nx    = '0;
          enter_drive = 1'b1;
        end
      end
      DRIVE: begin
        if (timer_q == DRIVE_LAST) begin
          timer_nx = '0;
          idx_nx   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (DEAD_CYCLES == 0) enter_drive = 1'b1;
          else                  state_nx    = BLANK;
        end
      end
      default: begin
        state_nx = BLANK;
        timer_nx = '0;
      end
    endcase
  end

  // The frame boundary is the only point where staged data may reach the
  // shadow, and the new shadow is rendered on that very edge.
  always_comb begin
    frame_start_nx = enter_drive && (idx_nx == '0);
    commit         = frame_start_nx && pending_q;
    shadow_d_nx    = commit ? stage_d_q  : shadow_d_q;
    shadow_dp_nx   = commit ? stage_dp_q : shadow_dp_q;
  end

  always_comb begin
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (shadow_d_nx[4*i +: 4] == 4'h0);
      lead_zero[i] = all_zero;
    end
  end

  always_comb nib_sel = shadow_d_nx[{idx_nx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nib_sel),
    .seg_n  (glyph)
  );

  always_comb begin
    seg_nx = SEG_OFF;
    an_nx  = '1;
    if (state_nx == DRIVE) begin
      an_nx[idx_nx]        = 1'b0;
      seg_nx[SEG_A:SEG_G]  = glyph;
      seg_nx[SEG_DP]       = ~shadow_dp_nx[idx_nx];
      if (bus.lz_blank && idx_nx != '0 && lead_zero[idx_nx])
        seg_nx[SEG_A:SEG_G] = 7'h7F;
      if (bus.blink_mask[idx_nx] && bus.blink_level)
        seg_nx = SEG_OFF;
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      timer_q       <= '0;
      stage_d_q     <= '0;
      stage_dp_q    <= '0;
      pending_q     <= 1'b0;
      shadow_d_q    <= '0;
      shadow_dp_q   <= '0;
      seg_q         <= SEG_OFF;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_nx;
      idx_q         <= idx_nx;
      timer_q       <= timer_nx;
      shadow_d_q    <= shadow_d_nx;
      shadow_dp_q   <= shadow_dp_nx;
      seg_q         <= seg_nx;
      an_q          <= an_nx;
      frame_start_q <= frame_start_nx;
      // A load on the commit edge lands in staging and stays pending.
      pending_q     <= bus.load | (pending_q & ~commit);
      if (bus.load) begin
        stage_d_q  <= bus.digits_in;
        stage_dp_q <= bus.dp_in;
      end
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_idx     = idx_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: 4 digits, 4-cycle on-time, 1-cycle dead-time,
// 20-cycle frames.
module tb_seg_scan_display;
  import seg7_pkg::*;

  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int DC    = 1;
  localparam int SLOT  = RD + DC;
  localparam int W     = 12;

  logic clk_fast = 1'b0;
  logic rst_n    = 1'b0;

  always #5 clk_fast = ~clk_fast;

  seg_scan_display_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_display #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0]      mask;
    logic            level;
    logic [3:0][7:0] exp_seg;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t           vecs [8];
  logic [W-1:0]   exp_q [$];
  int             checks = 0;
  int             passed = 0;
  int             cur_off = 0;
  int             last_steps = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk_fast);
    cur_off++;
  endtask

  task automatic goto_off(input int o);
    while (cur_off < o) step();
  endtask

  task automatic wait_frame_start();
    int n;
    n = 1;
    step();
    while (bus.frame_start !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    if (bus.frame_start !== 1'b1) check("frame_start_timeout", 16'(bus.frame_start), 16'h1);
    last_steps = n;
    cur_off    = 0;
  endtask

  function automatic logic [3:0] an_for(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  task automatic push_frame(input logic [3:0][7:0] s);
    for (int k = 0; k < N; k++) exp_q.push_back({an_for(k), s[k]});
  endtask

  task automatic check_digit(input int k);
    logic [W-1:0] e;
    goto_off(SLOT*k + 1);
    if (k == 0) check("frame_start_one_cycle", 16'(bus.frame_start), 16'h0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 16'(exp_q.size()), 16'h1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("digit%0d_an_seg", k), {4'h0, bus.an, bus.seg}, {4'h0, e});
    end
    goto_off(SLOT*k + RD);
    check($sformatf("blank_after_digit%0d", k), {4'h0, bus.an, bus.seg}, 16'h0FFF);
  endtask

  task automatic check_frame();
    for (int k = 0; k < N; k++) check_digit(k);
  endtask

  task automatic run_vec(input vec_t v);
    wait_frame_start();
    bus.digits_in   = v.digits;
    bus.dp_in       = v.dp;
    bus.lz_blank    = v.lz;
    bus.blink_mask  = v.mask;
    bus.blink_level = v.level;
    bus.load        = 1'b1;
    push_frame(v.exp_seg);
    step();
    bus.load = 1'b0;
    wait_frame_start();
    check_frame();
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] dp, input logic lz,
                              input logic [3:0] m, input logic lv, input logic [3:0][7:0] s);
    vec_t v;
    v.digits = d; v.dp = dp; v.lz = lz; v.mask = m; v.level = lv; v.exp_seg = s;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(16'hA9F0, 4'b0100, 1'b0, 4'b0000, 1'b0, {8'h11, 8'h08, 8'h71, 8'h03});
    vecs[1] = mk(16'h0050, 4'b0000, 1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'h49, 8'h03});
    vecs[2] = mk(16'h0000, 4'b0000, 1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h03});
    vecs[3] = mk(16'h0007, 4'b1000, 1'b1, 4'b0000, 1'b0, {8'hFE, 8'hFF, 8'hFF, 8'h1F});
    vecs[4] = mk(16'h1002, 4'b0000, 1'b1, 4'b0000, 1'b0, {8'h9F, 8'h03, 8'h03, 8'h25});
    vecs[5] = mk(16'hBCDE, 4'b1001, 1'b0, 4'b0000, 1'b0, {8'hC0, 8'h63, 8'h85, 8'h60});
    vecs[6] = mk(16'h5678, 4'b0000, 1'b0, 4'b0011, 1'b1, {8'h49, 8'h41, 8'hFF, 8'hFF});
    vecs[7] = mk(16'h5678, 4'b0000, 1'b0, 4'b0011, 1'b0, {8'h49, 8'h41, 8'h1F, 8'h01});

    bus.digits_in   = '0;
    bus.dp_in       = '0;
    bus.load        = 1'b0;
    bus.blink_mask  = '0;
    bus.blink_level = 1'b0;
    bus.lz_blank    = 1'b0;

    // Reset state
    #22;
    check("reset_an_seg", {4'h0, bus.an, bus.seg}, 16'h0FFF);
    check("reset_frame_start", 16'(bus.frame_start), 16'h0);
    check("reset_state", 16'(bus.dbg_state), 16'(BLANK));
    @(negedge clk_fast);
    rst_n = 1'b1;
    cur_off = 0;

    // Scan order after reset, cleared shadow shows 0 everywhere
    wait_frame_start();
    check("first_frame_latency", 16'(last_steps), 16'd1);
    push_frame({8'h03, 8'h03, 8'h03, 8'h03});
    check_frame();
    wait_frame_start();
    check("frame_period", 16'(last_steps + 19), 16'd20);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Double buffer: two loads mid-frame, last one wins at next frame
    bus.dp_in = '0;
    wait_frame_start();
    push_frame(vecs[5].exp_seg);
    bus.digits_in = 16'h1234;
    bus.load      = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    bus.digits_in = 16'h5678;
    bus.load      = 1'b1;
    step();
    bus.load = 1'b0;
    check_frame();
    wait_frame_start();
    push_frame({8'h49, 8'h41, 8'h1F, 8'h01});
    check_frame();

    // Load on the commit edge is held for one more frame
    bus.digits_in = 16'h1234;
    bus.load      = 1'b1;
    step();
    bus.load = 1'b0;
    cur_off  = 0;
    check("commit_edge_frame_start", 16'(bus.frame_start), 16'h1);
    push_frame({8'h49, 8'h41, 8'h1F, 8'h01});
    check_frame();
    wait_frame_start();
    push_frame({8'h9F, 8'h25, 8'h0D, 8'h99});
    check_frame();

    for (int v = 6; v < 8; v++) run_vec(vecs[v]);

    // Blink level toggled mid-digit
    wait_frame_start();
    step();
    check("blink_low_d0", {4'h0, bus.an, bus.seg}, 16'h0E01);
    bus.blink_level = 1'b1;
    step();
    check("blink_high_d0", {4'h0, bus.an, bus.seg}, 16'h0EFF);
    bus.blink_level = 1'b0;
    step();
    check("blink_low_again_d0", {4'h0, bus.an, bus.seg}, 16'h0E01);
    goto_off(SLOT*2);
    bus.blink_level = 1'b1;
    step();
    check("blink_unmasked_d2", {4'h0, bus.an, bus.seg}, 16'h0B41);
    bus.blink_level = 1'b0;

    // Async reset during digit 2 drive
    wait_frame_start();
    goto_off(SLOT*2 + 1);
    check("pre_reset_d2", {4'h0, bus.an, bus.seg}, 16'h0B41);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dark", {4'h0, bus.an, bus.seg}, 16'h0FFF);
    check("async_reset_frame_start", 16'(bus.frame_start), 16'h0);
    @(negedge clk_fast);
    @(negedge clk_fast);
    rst_n = 1'b1;
    cur_off = 0;
    wait_frame_start();
    check("restart_latency", 16'(last_steps), 16'd1);
    check("restart_idx", 16'(bus.dbg_idx), 16'h0);
    push_frame({8'h03, 8'h03, 8'h03, 8'h03});
    check_frame();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised multiplexed seven-segment driver. It is the next generation of the parking-meter display path.
- Scans NUM_DIGITS common-anode digits with a programmable on-time and a dead-time between digits for ghosting suppression.
- Full hex decode, per-digit decimal points, per-digit blink mask and optional leading-zero blanking.
- Digit data is double-buffered so a frame never tears. Sits between the meter counter/BCD logic and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clk_fast cycles each digit is driven; must be >= 1.
- DEAD_CYCLES, 2, cycles all anodes are off between digits; 0 disables the blank phase.

Ports:
- clk_fast  in  1  scan clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digits_in  in  4*NUM_DIGITS  hex nibbles; digit i is bits [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit).
- load  in  1  one-cycle strobe; captures digits_in and dp_in.
- blink_mask  in  NUM_DIGITS  digits subject to blinking.
- blink_level  in  1  slow blink phase; 1 = masked digits dark.
- lz_blank  in  1  enable leading-zero suppression.
- seg  out  8  active-low {a,b,c,d,e,f,g,dp}; seg[0] is dp.
- an  out  NUM_DIGITS  active-low anode enables.
- frame_start  out  1  one-cycle pulse when digit 0 enters DRIVE.

Behaviour:
- Reset (async, rst_n=0): an all 1, seg=8'hFF, frame_start=0, state BLANK, idx=0, timer=0. Staging, shadow and pending registers are cleared.
- Registers: state {BLANK, DRIVE}, idx (clog2(NUM_DIGITS), min 1 bit), timer (wide enough for max(REFRESH_DIV, DEAD_CYCLES)).
- BLANK: an all 1, seg=FF. After DEAD_CYCLES cycles the FSM moves to DRIVE for the current idx. If DEAD_CYCLES=0 it goes straight from DRIVE to the next DRIVE.
- DRIVE: an[idx]=0, all other anodes 1; seg = rendered(idx). After REFRESH_DIV cycles, idx advances, wrapping from NUM_DIGITS-1 to 0, and the FSM enters BLANK.
- Output timing: an, seg and frame_start are registered and change on the same edge as the state transition. There is no extra pipeline latency.
- Frame length: NUM_DIGITS*(REFRESH_DIV+DEAD_CYCLES) cycles.
- Buffering, capture: load copies the inputs into staging and sets pending.
- Buffering, commit: on the transition into DRIVE with idx=0, if pending, staging copies to shadow and pending clears.
- Buffering, timing: the committed data is rendered in that same cycle, and frame_start pulses in that cycle whether or not pending was set.
- Load while pending: staging is overwritten; last load wins.
- Load in the commit cycle: the new data goes to staging and pending stays set, so it is committed at the next frame.
- Rendered(i):
  - Base: seg7 hex decode of shadow nibble i, covering 0-F. Decode uses segments a-g only, bit 1 = off.
  - DP: dp bit = ~shadow_dp[i].
  - Leading-zero blank: if lz_blank=1, i>0, and shadow nibbles N-1 down to i are all 0, segments a-g are off; dp follows shadow_dp. Digit 0 is never suppressed.
  - Blink: if blink_mask[i] & blink_level, seg=FF, overriding everything else.
- blink_level is sampled every DRIVE cycle, so a level change takes effect mid-digit on the next edge. The input must be synchronous to clk_fast.
- Decode table, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset mid-frame: outputs go dark immediately (async). After release the scan restarts in BLANK at idx 0 with cleared shadow, so all digits display 0.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF (8'hFF)
  - the 16-entry SEG7_HEX constant table (7-bit)
  - segment bit-position constants
  - the state enum {BLANK, DRIVE}
- Sub-module seg7_decode: combinational, 4-bit nibble -> 7-bit active-low a-g; instantiated once on the muxed shadow nibble.

Test Plan:
- Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1; frame = 20 cycles.
- 1. Reset scan order: release reset, no load -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles with a 1-cycle 1111 gap between. seg=0000001_1 while driven. frame_start pulses every 20 cycles.
- 2. Hex decode and DP: load digits_in=16'hA9F0, dp_in=4'b0100 -> from the next frame_start:
  - digit0 seg=0000001_1, digit1 seg=0111000_1
  - digit2 seg=0000100_0, digit3 seg=0001000_1
- 3. Leading-zero blanking: lz_blank=1, digits_in=16'h0050 -> digit3 and digit2 seg=1111111_1, digit1 seg=0100100_1, digit0 seg=0000001_1. Then digits_in=16'h0000 -> only digit0 is lit, showing 0.
- 4. Double buffer: load 16'h1234 mid-frame, then load 16'h5678 two cycles later -> the current frame is unchanged; the next frame shows 5678 and 1234 never appears. A load in the commit cycle appears one frame later.
- 5. Blink: blink_mask=4'b0011 with blink_level toggled -> digits 0-1 show seg=FF while the level is high and normal glyphs while low; digits 2-3 are unaffected.
- 6. Async reset in DRIVE of digit 2 -> an=1111 and seg=FF with no clock edge. The scan restarts at digit 0 after release.
